can_crc_engine: RTL

Parametrised serial CRC engine for the CAN bit-stream path, and the next generation of the fixed CRC-15 shift register.
- Generator polynomial, width and seed are parameters.
- A sequencing FSM computes the CRC over the frame data bits, then either serialises the CRC for transmit or checks the received CRC field for receive.
- Sits between the bit-stuffing/destuffing stage and the frame FSM. It consumes one destuffed bit per `enable` strobe.

---
 rtl/can_crc_pkg.sv | 42 ++++
 rtl/can_crc_lfsr.sv | 54 +++++
 rtl/can_crc_engine.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/can_crc_pkg.sv
//------------------------------------------------------------------------------
// Module  : can_crc_pkg
// Purpose : Shared definitions for the CAN serial CRC engine: sequencing state
//           encoding, CAN CRC-15 default constants and the single-bit CRC
//           update function used by the register datapath and the result check.
// Ports   : none (package)
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package can_crc_pkg;

  localparam int                 CAN_CRC15_WIDTH = 15;
  localparam logic [14:0]        CAN_CRC15_POLY  = 15'h4599;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } crc_state_t;

  // One bit of the CRC recurrence on a register of width w (2..32), carried
  // in a 32-bit container. Bits above w are forced to zero in the result.
  function automatic logic [31:0] crc_step(
    input logic [31:0] crc,
    input logic        din,
    input logic [31:0] poly,
    input logic [5:0]  w
  );
    logic        fb;
    logic [31:0] mask;
    // w=32 wraps the 5-bit index to 31, the correct MSB position.
    fb   = din ^ crc[5'(w - 6'd1)];
    mask = w[5] ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ({crc[30:0], 1'b0} ^ (fb ? poly : 32'd0)) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/can_crc_lfsr.sv
//------------------------------------------------------------------------------
// Module  : can_crc_lfsr
// Purpose : Parametrised CRC register. Priority load > step > shift.
// Ports   : clock, reset_n (async, active low)
//           i_load  - load INIT
//           i_step  - apply the CRC recurrence with i_din
//           i_shift - shift left one place, zero fill (CRC serialisation)
//           i_din   - serial data bit for i_step
//           o_crc   - current register value
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module can_crc_lfsr
  import can_crc_pkg::*;
#(
  parameter int               WIDTH = 15,
  parameter logic [WIDTH-1:0] POLY  = CAN_CRC15_POLY,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_shift,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_crc
);

  logic [WIDTH-1:0] r_crc;
  logic [31:0]      w_step_full;
  logic             w_unused_step_hi;

  assign w_step_full      = crc_step(32'(r_crc), i_din, 32'(POLY), 6'(WIDTH));
  // Upper container bits are always zero; folded here only to consume them.
  assign w_unused_step_hi = ^w_step_full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= INIT;
    end else if (i_load) begin
      r_crc <= INIT;
    end else if (i_step) begin
      r_crc <= w_step_full[WIDTH-1:0];
    end else if (i_shift) begin
      r_crc <= {r_crc[WIDTH-2:0], 1'b0};
    end
  end

  assign o_crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/can_crc_engine.sv
//------------------------------------------------------------------------------
// Module  : can_crc_engine
// Purpose : Serial CRC engine for the CAN bit-stream path. Computes the CRC
//           over destuffed frame data bits, then either serialises it (tx) or
//           runs the received CRC field through the register and checks for a
//           zero residue (rx).
// Ports   : clock, reset_n (async, active low)
//           start, tx_mode, enable, data_in, data_end   - control/data inputs
//           crc, crc_bit_out, crc_bit_valid              - CRC register / tx bit
//           busy, done, crc_ok, crc_error                - status
//           bit_count                                    - data bits consumed
// Config  : CAN_CRC_BITCOUNT_EN - when defined, bit_count counts data bits
//           consumed in CALC (saturating); otherwise bit_count is tied to 0.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module can_crc_engine
  import can_crc_pkg::*;
#(
  parameter int                   CRC_WIDTH = CAN_CRC15_WIDTH,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CAN_CRC15_POLY,
  parameter logic [CRC_WIDTH-1:0] CRC_INIT  = '0,
  parameter int                   CNT_WIDTH = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 tx_mode,
  input  logic                 enable,
  input  logic                 data_in,
  input  logic                 data_end,
  output logic [CRC_WIDTH-1:0] crc,
  output logic                 crc_bit_out,
  output logic                 crc_bit_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_ok,
  output logic                 crc_error,
  output logic [CNT_WIDTH-1:0] bit_count
);

  localparam int                  c_SCNT_W = (CRC_WIDTH > 2) ? $clog2(CRC_WIDTH) : 1;
  localparam logic [c_SCNT_W-1:0] c_LAST   = c_SCNT_W'(CRC_WIDTH - 1);

  crc_state_t            r_state;
  crc_state_t            w_state_nxt;
  logic                  r_tx_mode;
  logic [c_SCNT_W-1:0]   r_cnt;
  logic [c_SCNT_W-1:0]   w_cnt_nxt;
  logic                  r_crc_ok;
  logic                  r_crc_error;
  logic                  w_load;
  logic                  w_step;
  logic                  w_shift;
  logic                  w_last;
  logic [CRC_WIDTH-1:0]  w_crc;
  logic [31:0]           w_chk_full;
  logic                  w_chk_zero;

  can_crc_lfsr #(
    .WIDTH (CRC_WIDTH),
    .POLY  (CRC_POLY),
    .INIT  (CRC_INIT)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_shift (w_shift),
    .i_din   (data_in),
    .o_crc   (w_crc)
  );

  // Residue after the final CHECK bit, so the verdict matches the value the
  // register will hold once the last received CRC bit is absorbed.
  assign w_chk_full = crc_step(32'(w_crc), data_in, 32'(CRC_POLY), 6'(CRC_WIDTH));
  assign w_chk_zero = (w_chk_full == 32'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    if (start) begin
      w_state_nxt = ST_CALC;
      w_load      = 1'b1;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_CALC: begin
          // A bit strobed together with data_end is still consumed.
          w_step = enable;
          if (data_end) begin
            w_state_nxt = r_tx_mode ? ST_SHIFT : ST_CHECK;
            w_cnt_nxt   = '0;
          end
        end
        ST_SHIFT, ST_CHECK: begin
          if (enable) begin
            w_shift = (r_state == ST_SHIFT);
            w_step  = (r_state == ST_CHECK);
            if (r_cnt == c_LAST) begin
              w_last      = 1'b1;
              w_state_nxt = ST_DONE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + c_SCNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tx_mode   <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (start) begin
        r_tx_mode   <= tx_mode;
        r_crc_ok    <= 1'b0;
        r_crc_error <= 1'b0;
      end else if (w_last && (r_state == ST_CHECK)) begin
        r_crc_ok    <= w_chk_zero;
        r_crc_error <= !w_chk_zero;
      end
    end
  end

`ifdef CAN_CRC_BITCOUNT_EN
  logic [CNT_WIDTH-1:0] r_bit_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_count <= '0;
    end else if (start) begin
      r_bit_count <= '0;
    end else if ((r_state == ST_CALC) && enable && !(&r_bit_count)) begin
      r_bit_count <= r_bit_count + CNT_WIDTH'(1);
    end
  end

  assign bit_count = r_bit_count;
`else
  assign bit_count = '0;
`endif

  assign crc           = w_crc;
  assign crc_bit_valid = (r_state == ST_SHIFT);
  assign crc_bit_out   = (r_state == ST_SHIFT) & w_crc[CRC_WIDTH-1];
  assign busy          = (r_state == ST_CALC) || (r_state == ST_SHIFT) || (r_state == ST_CHECK);
  assign done          = (r_state == ST_DONE);
  assign crc_ok        = r_crc_ok;
  assign crc_error     = r_crc_error;

endmodule

`default_nettype wire
